io_port_controller: RTL and testbench
=====================================

IO_PORT_CONTROLLER -- requirements
Module: io_port_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per FIFO; power of two, 2..16.
REQ-002 SHALL have parameter INT_HOLDOFF, default 4, meaning cycles cpu_int stays masked after a pulse; this covers the interrupt drain through decode, execute, memory and WB.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-005 SHALL have port cpu_out_data, input, 16: processor Out_Port value.
REQ-006 SHALL have port cpu_out_wr, input, 1: one-cycle pulse when an OUT instruction is in execute.
REQ-007 SHALL have port cpu_in_rd, input, 1: one-cycle pulse when an IN instruction consumes In_Port.
REQ-008 SHALL have port cpu_in_data, output, 16: drives processor In_Port.
REQ-009 SHALL have port cpu_int, output, 1: drives processor int.
REQ-010 SHALL have ports ext_rx_data (input, 16), ext_rx_valid (input, 1) and ext_rx_ready (output, 1): external-to-CPU stream.
REQ-011 SHALL have ports ext_tx_data (output, 16), ext_tx_valid (output, 1) and ext_tx_ready (input, 1): CPU-to-external stream.
REQ-012 SHALL have port tx_overflow, output, 1: sticky flag, set when an OUT word is dropped.

Function
REQ-013 SHALL hold incoming words in an RX FIFO of DEPTH entries; a word is pushed on each rising edge where ext_rx_valid and ext_rx_ready are both 1.
REQ-014 SHALL drive ext_rx_ready = RX not full, combinationally from registered occupancy.
REQ-015 SHALL present the RX head on cpu_in_data first-word fall-through, and drive 16'h0000 when RX is empty.
REQ-016 SHALL pop RX on cpu_in_rd when RX is non-empty; cpu_in_rd on an empty RX SHALL be ignored with no pointer change.
REQ-017 SHALL, on simultaneous push and pop on RX, keep occupancy unchanged; on an empty RX, SHALL accept the push and ignore the pop.
REQ-018 SHALL hold outgoing words in a TX FIFO of DEPTH entries; a word is pushed on cpu_out_wr, since the processor cannot be stalled.
REQ-019 SHALL drive ext_tx_valid = TX not empty, with ext_tx_data = TX head; TX pops when ext_tx_valid and ext_tx_ready are both 1.
REQ-020 SHALL, on cpu_out_wr with TX full, drop the word and set tx_overflow, unless a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-021 SHALL wrap pointers modulo DEPTH and track occupancy in a $clog2(DEPTH)+1-bit counter; full = count==DEPTH, empty = count==0.
REQ-022 SHALL implement the interrupt FSM with states IDLE, PULSE and HOLD.
REQ-023 SHALL, in IDLE with the armed flag set and RX non-empty, transition to PULSE and clear the armed flag.
REQ-024 SHALL drive cpu_int=1 for exactly one cycle in PULSE, then transition to HOLD with the counter loaded to INT_HOLDOFF-1.
REQ-025 SHALL, in HOLD, decrement the counter each cycle and return to IDLE after the count reaches 0; cpu_int SHALL be 0 throughout HOLD.
REQ-026 SHALL set the armed flag whenever RX occupancy is 0, in any FSM state; one interrupt is therefore raised per empty-to-non-empty burst.
REQ-027 SHALL register cpu_int directly from FSM state, with no combinational path from inputs.

Reset
REQ-028 SHALL, on reset asserted, immediately clear both FIFOs' pointers and counts, set the FSM to IDLE, set the armed flag to 1, clear tx_overflow, clear the hold counter and set cpu_int to 0.
REQ-029 SHALL, while reset is asserted, drive cpu_in_data=0, ext_tx_valid=0 and ext_rx_ready=1; FIFO storage contents need not be cleared.
REQ-030 SHALL abort an in-progress PULSE or HOLD on reset asserted mid-operation, and SHALL lose no state beyond what REQ-028 clears.

Configuration
REQ-031 SHALL use the macro IO_PORT_INT_EN: when defined, the interrupt FSM of REQ-022..027 SHALL be compiled in.
REQ-032 SHALL, when IO_PORT_INT_EN is undefined, omit the FSM, armed flag and counter, and tie cpu_int to 0; FIFO behaviour SHALL be unchanged.

Verification
REQ-033 SHALL cover: reset, then push ext_rx 0x1234 -> cpu_in_data=0x1234 next cycle, cpu_int high exactly one cycle (INT_EN), then low for 4 cycles.
REQ-034 SHALL cover: push 5 RX words with DEPTH=4 and no reads -> ext_rx_ready=0 after the 4th word, 5th word held off, only one cpu_int pulse.
REQ-035 SHALL cover: cpu_in_rd on empty RX -> cpu_in_data stays 0x0000, count stays 0, no interrupt.
REQ-036 SHALL cover: 5 cpu_out_wr of 0xA0..0xA4 with ext_tx_ready=0 -> 0xA4 dropped, tx_overflow=1, and with ready=1 later, words 0xA0..0xA3 emitted in order.
REQ-037 SHALL cover: TX full with cpu_out_wr and ext_tx_ready both 1 in the same cycle -> word accepted, count stays 4, tx_overflow stays 0.
REQ-038 SHALL cover: reset asserted in HOLD with 2 RX words stored -> cpu_int=0, RX empty, FSM in IDLE; the next RX push raises a new pulse.

Source files
------------

// File: rtl/io_port_controller.sv
// rtl/io_port_controller.sv - CPU I/O port bridge with RX/TX FIFOs and interrupt on RX arrival
// Define IO_PORT_INT_EN to build the RX-arrival interrupt FSM; otherwise cpu_int is tied low.
module io_port_controller #(
  parameter int DEPTH       = 4,
  parameter int INT_HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_out_data,
  input  logic        cpu_out_wr,
  input  logic        cpu_in_rd,
  output logic [15:0] cpu_in_data,
  output logic        cpu_int,
  input  logic [15:0] ext_rx_data,
  input  logic        ext_rx_valid,
  output logic        ext_rx_ready,
  output logic [15:0] ext_tx_data,
  output logic        ext_tx_valid,
  input  logic        ext_tx_ready,
  output logic        tx_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("io_port_controller: DEPTH must be a power of two in 2..16");
  end
  if (INT_HOLDOFF < 1) begin : g_bad_holdoff
    $error("io_port_controller: INT_HOLDOFF must be at least 1");
  end

  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr, rx_rptr;
  logic [CW-1:0] rx_count;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  logic [15:0]   tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr;
  logic [CW-1:0] tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_push  = ext_rx_valid & ~rx_full;
  assign rx_pop   = cpu_in_rd & ~rx_empty;

  assign ext_rx_ready = ~rx_full;
  assign cpu_in_data  = rx_empty ? 16'h0000 : rx_mem[rx_rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr] <= ext_rx_data;
  end

  // The processor cannot stall on OUT, so a full TX only drops when nothing drains that cycle.
  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_pop   = ~tx_empty & ext_tx_ready;
  assign tx_push  = cpu_out_wr & (~tx_full | tx_pop);

  assign ext_tx_valid = ~tx_empty;
  assign ext_tx_data  = tx_mem[tx_rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      tx_count    <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
      if (cpu_out_wr && tx_full && !tx_pop) tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr] <= cpu_out_data;
  end

`ifdef IO_PORT_INT_EN
  localparam int HW = $clog2(INT_HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} int_state_t;

  int_state_t    int_state;
  logic          armed;
  logic [HW-1:0] hold_cnt;
  logic          int_q;

  // armed re-arms only on an empty RX, so a burst raises a single interrupt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_state <= IDLE;
      armed     <= 1'b1;
      hold_cnt  <= '0;
      int_q     <= 1'b0;
    end else begin
      case (int_state)
        IDLE: begin
          if (armed && !rx_empty) begin
            int_state <= PULSE;
            armed     <= 1'b0;
            int_q     <= 1'b1;
          end
        end
        PULSE: begin
          int_state <= HOLD;
          int_q     <= 1'b0;
          hold_cnt  <= HW'(INT_HOLDOFF - 1);
        end
        HOLD: begin
          if (hold_cnt == '0) int_state <= IDLE;
          else                hold_cnt  <= hold_cnt - 1'b1;
        end
        default: begin
          int_state <= IDLE;
          int_q     <= 1'b0;
        end
      endcase
      if (rx_empty) armed <= 1'b1;
    end
  end

  assign cpu_int = int_q;
`else
  assign cpu_int = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_controller.sv
// tb/tb_io_port_controller.sv - directed self-checking bench for io_port_controller
module tb_io_port_controller;

`ifdef IO_PORT_INT_EN
  localparam logic INT_EN = 1'b1;
`else
  localparam logic INT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] cpu_out_data;
  logic        cpu_out_wr;
  logic        cpu_in_rd;
  logic [15:0] cpu_in_data;
  logic        cpu_int;
  logic [15:0] ext_rx_data;
  logic        ext_rx_valid;
  logic        ext_rx_ready;
  logic [15:0] ext_tx_data;
  logic        ext_tx_valid;
  logic        ext_tx_ready;
  logic        tx_overflow;

  int checks = 0;
  int passes = 0;
  int pulses = 0;

  io_port_controller #(.DEPTH(4), .INT_HOLDOFF(4)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_out_data(cpu_out_data),
    .cpu_out_wr(cpu_out_wr),
    .cpu_in_rd(cpu_in_rd),
    .cpu_in_data(cpu_in_data),
    .cpu_int(cpu_int),
    .ext_rx_data(ext_rx_data),
    .ext_rx_valid(ext_rx_valid),
    .ext_rx_ready(ext_rx_ready),
    .ext_tx_data(ext_tx_data),
    .ext_tx_valid(ext_tx_valid),
    .ext_tx_ready(ext_tx_ready),
    .tx_overflow(tx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_out_data = 16'h0;
    cpu_out_wr = 1'b0;
    cpu_in_rd = 1'b0;
    ext_rx_data = 16'h0;
    ext_rx_valid = 1'b0;
    ext_tx_ready = 1'b0;
    #1;
    chk("rst_in_data", cpu_in_data, 16'h0000);
    chk("rst_tx_valid", ext_tx_valid, 1'b0);
    chk("rst_rx_ready", ext_rx_ready, 1'b1);
    chk("rst_int", cpu_int, 1'b0);
    chk("rst_ovf", tx_overflow, 1'b0);
    step();
    step();
    reset = 1'b0;

    // single RX word: fall-through, one pulse, then hold-off
    ext_rx_data = 16'h1234;
    ext_rx_valid = 1'b1;
    step();
    ext_rx_valid = 1'b0;
    chk("fwft_data", cpu_in_data, 16'h1234);
    chk("int_before_pulse", cpu_int, 1'b0);
    step();
    chk("int_pulse", cpu_int, INT_EN);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("int_hold_low", cpu_int, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("int_no_repeat", cpu_int, 1'b0);
    end
    chk("data_held", cpu_in_data, 16'h1234);
    cpu_in_rd = 1'b1;
    step();
    cpu_in_rd = 1'b0;
    chk("pop_to_empty", cpu_in_data, 16'h0000);

    // read on empty RX is ignored
    cpu_in_rd = 1'b1;
    step();
    cpu_in_rd = 1'b0;
    chk("empty_rd_data", cpu_in_data, 16'h0000);
    chk("empty_rd_ready", ext_rx_ready, 1'b1);
    chk("empty_rd_int", cpu_int, 1'b0);

    // simultaneous push and pop keeps occupancy
    ext_rx_data = 16'h5555;
    ext_rx_valid = 1'b1;
    step();
    ext_rx_data = 16'h6666;
    cpu_in_rd = 1'b1;
    step();
    ext_rx_valid = 1'b0;
    cpu_in_rd = 1'b0;
    chk("pushpop_head", cpu_in_data, 16'h6666);
    chk("pushpop_int", cpu_int, INT_EN);
    cpu_in_rd = 1'b1;
    step();
    cpu_in_rd = 1'b0;
    chk("pushpop_count1", cpu_in_data, 16'h0000);
    for (int i = 0; i < 6; i++) step();

    // five RX words into a depth-4 FIFO
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      ext_rx_data = 16'h0011 + 16'(i);
      ext_rx_valid = 1'b1;
      step();
      chk("rx_fill_ready", ext_rx_ready, (i < 3) ? 1'b1 : 1'b0);
      pulses += int'(cpu_int);
    end
    ext_rx_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(cpu_int);
    end
    chk("rx_fill_pulses", 16'(pulses), 16'(INT_EN));
    for (int j = 0; j < 4; j++) begin
      chk("rx_drain_order", cpu_in_data, 16'h0011 + 16'(j));
      cpu_in_rd = 1'b1;
      step();
      cpu_in_rd = 1'b0;
    end
    chk("rx_drain_empty", cpu_in_data, 16'h0000);
    chk("rx_drain_ready", ext_rx_ready, 1'b1);
    for (int i = 0; i < 6; i++) step();

    // TX overflow on the fifth OUT with the sink stalled
    ext_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_out_data = 16'h00A0 + 16'(i);
      cpu_out_wr = 1'b1;
      step();
      chk("tx_ovf_flag", tx_overflow, (i == 4) ? 1'b1 : 1'b0);
    end
    cpu_out_wr = 1'b0;
    chk("tx_valid_full", ext_tx_valid, 1'b1);
    ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("tx_order", ext_tx_data, 16'h00A0 + 16'(i));
      chk("tx_valid", ext_tx_valid, 1'b1);
      step();
    end
    ext_tx_ready = 1'b0;
    chk("tx_drained", ext_tx_valid, 1'b0);
    chk("tx_ovf_sticky", tx_overflow, 1'b1);

    // full TX with a write and a drain in the same cycle
    do_reset();
    chk("ovf_after_reset", tx_overflow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cpu_out_data = 16'h00B0 + 16'(i);
      cpu_out_wr = 1'b1;
      step();
    end
    cpu_out_data = 16'h00B4;
    ext_tx_ready = 1'b1;
    step();
    cpu_out_wr = 1'b0;
    ext_tx_ready = 1'b0;
    chk("wr_pop_ovf", tx_overflow, 1'b0);
    chk("wr_pop_head", ext_tx_data, 16'h00B1);
    cpu_out_data = 16'h00B5;
    cpu_out_wr = 1'b1;
    step();
    cpu_out_wr = 1'b0;
    chk("wr_pop_still_full", tx_overflow, 1'b1);
    ext_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wr_pop_order", ext_tx_data, 16'h00B1 + 16'(i));
      step();
    end
    ext_tx_ready = 1'b0;
    chk("wr_pop_drained", ext_tx_valid, 1'b0);

    // reset while the interrupt is in HOLD with two RX words stored
    ext_rx_data = 16'h00C1;
    ext_rx_valid = 1'b1;
    step();
    ext_rx_data = 16'h00C2;
    step();
    ext_rx_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("midrst_int", cpu_int, 1'b0);
    chk("midrst_in_data", cpu_in_data, 16'h0000);
    chk("midrst_rx_ready", ext_rx_ready, 1'b1);
    chk("midrst_tx_valid", ext_tx_valid, 1'b0);
    step();
    reset = 1'b0;
    chk("postrst_in_data", cpu_in_data, 16'h0000);
    ext_rx_data = 16'h00D1;
    ext_rx_valid = 1'b1;
    step();
    ext_rx_valid = 1'b0;
    chk("postrst_head", cpu_in_data, 16'h00D1);
    step();
    chk("postrst_pulse", cpu_int, INT_EN);
    step();
    chk("postrst_pulse_end", cpu_int, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
